// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Data-memory responder for the execute-stage memory interface.
//           Masked byte writes, fixed-latency pipelined reads, and automatic
//           splitting of accesses that straddle a 32-bit word boundary.
//           Optional feature macro: DMEM_ZERO_INIT_EN (clears the array after
//           reset, one word per cycle, while stalling the initiator).
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_in,
  input  logic [31:0] mem_write_addr_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [7:0]  mem_write_mask_in,
  input  logic        mem_read_in,
  input  logic [31:0] mem_read_addr_in,
  output logic [31:0] read_data_out,
  output logic        read_valid_out,
  output logic        stall_out,
  output logic        error_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_ZERO_INIT_EN
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPLIT_WR = 2'd1,
    SPLIT_RD = 2'd2,
    INIT     = 2'd3
  } state_e;
  localparam state_e RESET_STATE = INIT;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPLIT_WR = 2'd1,
    SPLIT_RD = 2'd2
  } state_e;
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e state_q, state_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Second-half context shared by split writes and split reads
  logic [AW-1:0] sp_word_q, sp_word_d;
  logic [31:0]   sp_data_q, sp_data_d;
  logic [3:0]    sp_be_q,   sp_be_d;
  logic [1:0]    sp_off_q,  sp_off_d;
  logic [31:0]   rd_w0_q,   rd_w0_d;
  logic          err_q,     err_d;
`ifdef DMEM_ZERO_INIT_EN
  logic [AW-1:0] sweep_q,   sweep_d;
`endif

  // Array write port
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [3:0]    wbe;

  // Read pipeline entry
  logic          push;
  logic [31:0]   push_data;

  // Address decode; the borrow bit of the 33-bit subtraction flags addr < BASE_ADDR
  logic [32:0]   wr_rel, rd_rel;
  logic [AW-1:0] wr_word, rd_word;
  logic [1:0]    wr_off, rd_off;
  logic          wr_oor, rd_oor;

  assign wr_rel  = {1'b0, mem_write_addr_in} - {1'b0, BASE_ADDR};
  assign rd_rel  = {1'b0, mem_read_addr_in}  - {1'b0, BASE_ADDR};
  assign wr_word = wr_rel[AW+1:2];
  assign rd_word = rd_rel[AW+1:2];
  assign wr_off  = wr_rel[1:0];
  assign rd_off  = rd_rel[1:0];
  assign wr_oor  = wr_rel[32] | (|wr_rel[31:AW+2]);
  assign rd_oor  = rd_rel[32] | (|rd_rel[31:AW+2]);

  // Only byte, half and word enables are meaningful; zero is a legal no-op
  logic wr_mask_bad;
  assign wr_mask_bad = (mem_write_mask_in[7:4] != 4'h0) ||
                       !((mem_write_mask_in[3:0] == 4'h0) ||
                         (mem_write_mask_in[3:0] == 4'h1) ||
                         (mem_write_mask_in[3:0] == 4'h3) ||
                         (mem_write_mask_in[3:0] == 4'hF));

  // Lane-shifted write; the upper nibble/word belongs to the next array word
  logic [7:0]  sh_mask;
  logic [63:0] sh_data;
  assign sh_mask = {4'h0, mem_write_mask_in[3:0]} << wr_off;
  assign sh_data = {32'h0, mem_write_data_in} << {wr_off, 3'b000};

  // Single read port: request word in IDLE, following word in SPLIT_RD
  logic [AW-1:0] rd_idx;
  logic [31:0]   mem_rd;
  assign rd_idx = (state_q == SPLIT_RD) ? sp_word_q : rd_word;
  assign mem_rd = mem_q[rd_idx];

  // Funnel-shift the two captured words so the request byte lands in bits [7:0]
  logic [31:0] rd_split;
  always_comb begin
    rd_split = rd_w0_q;
    case (sp_off_q)
      2'd1:    rd_split = {mem_rd[7:0],  rd_w0_q[31:8]};
      2'd2:    rd_split = {mem_rd[15:0], rd_w0_q[31:16]};
      2'd3:    rd_split = {mem_rd[23:0], rd_w0_q[31:24]};
      default: rd_split = rd_w0_q;
    endcase
  end

  // Next-state, array port and pipeline-entry decode
  always_comb begin
    state_d   = state_q;
    we        = 1'b0;
    waddr     = wr_word;
    wdata     = sh_data[31:0];
    wbe       = sh_mask[3:0];
    push      = 1'b0;
    push_data = 32'h0;
    err_d     = 1'b0;
    sp_word_d = sp_word_q;
    sp_data_d = sp_data_q;
    sp_be_d   = sp_be_q;
    sp_off_d  = sp_off_q;
    rd_w0_d   = rd_w0_q;
`ifdef DMEM_ZERO_INIT_EN
    sweep_d   = sweep_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_write_in) begin
          if (wr_mask_bad || wr_oor) begin
            err_d = 1'b1;
          end else if (mem_write_mask_in[3:0] != 4'h0) begin
            we = 1'b1;
            if (sh_mask[7:4] != 4'h0) begin
              sp_word_d = wr_word + 1'b1;
              sp_data_d = sh_data[63:32];
              sp_be_d   = sh_mask[7:4];
              state_d   = SPLIT_WR;
            end
          end
          // A read alongside a write is dropped and flagged
          if (mem_read_in) begin
            err_d = 1'b1;
          end
        end else if (mem_read_in) begin
          if (rd_oor) begin
            err_d     = 1'b1;
            push      = 1'b1;
            push_data = 32'h0;
          end else if (rd_off == 2'd0) begin
            push      = 1'b1;
            push_data = mem_rd;
          end else begin
            rd_w0_d   = mem_rd;
            sp_word_d = rd_word + 1'b1;
            sp_off_d  = rd_off;
            state_d   = SPLIT_RD;
          end
        end
      end
      SPLIT_WR: begin
        we      = 1'b1;
        waddr   = sp_word_q;
        wdata   = sp_data_q;
        wbe     = sp_be_q;
        state_d = IDLE;
      end
      SPLIT_RD: begin
        push      = 1'b1;
        push_data = rd_split;
        state_d   = IDLE;
      end
`ifdef DMEM_ZERO_INIT_EN
      INIT: begin
        we      = 1'b1;
        waddr   = sweep_q;
        wdata   = 32'h0;
        wbe     = 4'hF;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_WORD) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Reset abandons any second half and anything not yet in the pipeline
    if (reset) begin
      we   = 1'b0;
      push = 1'b0;
    end
  end

  // FSM and split-context registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      sp_word_q <= '0;
      sp_data_q <= 32'h0;
      sp_be_q   <= 4'h0;
      sp_off_q  <= 2'd0;
      rd_w0_q   <= 32'h0;
      err_q     <= 1'b0;
`ifdef DMEM_ZERO_INIT_EN
      sweep_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sp_word_q <= sp_word_d;
      sp_data_q <= sp_data_d;
      sp_be_q   <= sp_be_d;
      sp_off_q  <= sp_off_d;
      rd_w0_q   <= rd_w0_d;
      err_q     <= err_d;
`ifdef DMEM_ZERO_INIT_EN
      sweep_q   <= sweep_d;
`endif
    end
  end

  // Byte-enabled array write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read latency pipeline; data stages load only behind a valid so the output holds
  logic [READ_LATENCY-1:0] pv_q;
  logic [31:0]             pd_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd_q[i] <= 32'h0;
      end
    end else begin
      pv_q[0] <= push;
      if (push) begin
        pd_q[0] <= push_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
        end
      end
    end
  end

  assign read_valid_out = pv_q[READ_LATENCY-1];
  assign read_data_out  = pd_q[READ_LATENCY-1];
  assign stall_out      = (state_q != IDLE);
  assign error_out      = err_q;

endmodule
`default_nettype wire
